// File: rtl/uart_core_param.sv
// UART core: TX and RX engines on one fractional baud generator, with TX/RX FIFOs and saturating error counters.
// Optional UART_LOOPBACK_EN adds lb_i, which feeds TX serial into RX and holds Tx_o high.

module uart_core_param_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [W-1:0] wdata_i,
  input  logic         re_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2**AW];
  logic [AW:0]  wp_q, rp_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (we_i) wp_q <= wp_q + 1'b1;
      if (re_i) rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) if (we_i) mem_q[wp_q[AW-1:0]] <= wdata_i;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  assign rdata_o = empty_o ? '0 : mem_q[rp_q[AW-1:0]];
endmodule

module uart_core_param #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4,
  parameter int OVS     = 16,
  parameter int DIV_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_We_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [3:0]        frac_i,
  input  logic [3:0]        cfg_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              n_we_i,
  output logic              p_full_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              n_rd_i,
  output logic              p_empty_o,
  output logic              p_tx_busy_o,
  output logic [7:0]        ParityErrNum_o,
  output logic [7:0]        FrameErrNum_o,
  output logic [7:0]        OverrunNum_o,
`ifdef UART_LOOPBACK_EN
  input  logic              lb_i,
`endif
  input  logic              Rx_i,
  output logic              Tx_o
);
  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2, S_WAIT} st_e;

  logic [DIV_W-1:0] div_q, bcnt_q;
  logic [3:0]       frac_q, cfg_q, acc_q;
  logic             long_q, tick;
  logic [4:0]       acc_sum;
  logic [DIV_W:0]   bper;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q  <= DIV_W'(16);
      frac_q <= '0;
      cfg_q  <= '0;
    end else if (p_We_i) begin
      div_q  <= div_i;
      frac_q <= frac_i;
      cfg_q  <= cfg_i;
    end
  end

  // Accumulator carry stretches the following tick period by one clock.
  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
  assign bper    = {1'b0, div_q} + {{DIV_W{1'b0}}, long_q} - {{DIV_W{1'b0}}, 1'b1};
  assign tick    = ({1'b0, bcnt_q} >= bper);

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcnt_q <= '0;
      acc_q  <= '0;
      long_q <= 1'b0;
    end else if (tick) begin
      bcnt_q <= '0;
      acc_q  <= acc_sum[3:0];
      long_q <= acc_sum[4];
    end else begin
      bcnt_q <= bcnt_q + 1'b1;
    end
  end

  // ---------------- TX ----------------
  st_e              tx_st_q, tx_st_d;
  logic [CW-1:0]    tx_ovs_q;
  logic [BW-1:0]    tx_bit_q;
  logic [DATA_W-1:0] tx_sh_q, txf_data;
  logic [3:0]       tx_cfg_q;
  logic             tx_par_q, tx_end, tx_pop, tx_ser, txf_full, txf_empty;

  uart_core_param_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_txf (
    .clk(clk), .rst(rst), .we_i(!n_we_i && !txf_full), .wdata_i(data_i),
    .re_i(tx_pop), .rdata_o(txf_data), .full_o(txf_full), .empty_o(txf_empty)
  );

  assign tx_end = tick && (tx_ovs_q == CW'(OVS-1));
  assign tx_pop = tick && !txf_empty &&
                  ((tx_st_q == S_IDLE) ||
                   (tx_end && ((tx_st_q == S_STOP2) || (tx_st_q == S_STOP1 && !tx_cfg_q[0]))));

  always_ff @(posedge clk) begin
    if (!rst) tx_st_q <= S_IDLE;
    else      tx_st_q <= tx_st_d;
  end

  always_comb begin
    tx_st_d = tx_st_q;
    case (tx_st_q)
      S_IDLE:  if (tx_pop) tx_st_d = S_START;
      S_START: if (tx_end) tx_st_d = S_DATA;
      S_DATA:  if (tx_end && tx_bit_q == BW'(DATA_W-1)) tx_st_d = tx_cfg_q[2] ? S_PAR : S_STOP1;
      S_PAR:   if (tx_end) tx_st_d = S_STOP1;
      S_STOP1: if (tx_end) tx_st_d = tx_cfg_q[0] ? S_STOP2 : (tx_pop ? S_START : S_IDLE);
      S_STOP2: if (tx_end) tx_st_d = tx_pop ? S_START : S_IDLE;
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ser = 1'b1;
    case (tx_st_q)
      S_START: tx_ser = 1'b0;
      S_DATA:  tx_ser = tx_cfg_q[3] ? tx_sh_q[DATA_W-1] : tx_sh_q[0];
      S_PAR:   tx_ser = tx_par_q;
      default: tx_ser = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_ovs_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0; tx_cfg_q <= '0; tx_par_q <= 1'b0;
    end else if (tx_pop) begin
      tx_ovs_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= txf_data;
      tx_cfg_q <= cfg_q;
      tx_par_q <= (^txf_data) ^ cfg_q[1];
    end else if (tick && tx_st_q != S_IDLE) begin
      tx_ovs_q <= tx_end ? '0 : tx_ovs_q + 1'b1;
      if (tx_end && tx_st_q == S_DATA) begin
        tx_bit_q <= tx_bit_q + 1'b1;
        tx_sh_q  <= tx_cfg_q[3] ? {tx_sh_q[DATA_W-2:0], 1'b0} : {1'b0, tx_sh_q[DATA_W-1:1]};
      end
    end
  end

  assign p_tx_busy_o = (tx_st_q != S_IDLE) || !txf_empty;
  assign p_full_o    = txf_full;

  // ---------------- RX ----------------
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = lb_i ? tx_ser : Rx_i;
  assign Tx_o   = lb_i ? 1'b1 : tx_ser;
`else
  assign rx_src = Rx_i;
  assign Tx_o   = tx_ser;
`endif

  st_e               rx_st_q, rx_st_d;
  logic              rx_s1_q, rx_s2_q, rx_prev_q, rx_perr_q, rx_fall, rx_mid, rx_maj;
  logic [1:0]        rx_smp_q;
  logic [CW-1:0]     rx_ovs_q;
  logic [BW-1:0]     rx_bit_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [3:1]        rx_cfg_q;
  logic              rx_push, rx_pop, rx_ferr, rxf_full, rxf_empty;
  logic [7:0]        perr_q, ferr_q, ovr_q;

  assign rx_fall = rx_prev_q && !rx_s2_q;
  // Decision on the third of three consecutive samples centred on mid-bit.
  assign rx_mid  = tick && (rx_ovs_q == CW'(OVS/2+1));
  assign rx_maj  = (rx_smp_q[1] & rx_smp_q[0]) | (rx_smp_q[1] & rx_s2_q) | (rx_smp_q[0] & rx_s2_q);

  always_ff @(posedge clk) begin
    if (!rst) rx_st_q <= S_IDLE;
    else      rx_st_q <= rx_st_d;
  end

  always_comb begin
    rx_st_d = rx_st_q;
    case (rx_st_q)
      S_IDLE:  if (rx_fall) rx_st_d = S_START;
      S_START: if (rx_mid) rx_st_d = rx_maj ? S_IDLE : S_DATA;
      S_DATA:  if (rx_mid && rx_bit_q == BW'(DATA_W-1)) rx_st_d = rx_cfg_q[2] ? S_PAR : S_STOP1;
      S_PAR:   if (rx_mid) rx_st_d = S_STOP1;
      S_STOP1: if (rx_mid) rx_st_d = rx_maj ? S_IDLE : S_WAIT;
      S_WAIT:  if (rx_s2_q) rx_st_d = S_IDLE;
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_push = (rx_st_q == S_STOP1) && rx_mid && rx_maj;
    rx_ferr = (rx_st_q == S_STOP1) && rx_mid && !rx_maj;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1; rx_smp_q <= 2'b11;
      rx_ovs_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0; rx_cfg_q <= '0; rx_perr_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx_src;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (tick) rx_smp_q <= {rx_smp_q[0], rx_s2_q};
      if (rx_st_q == S_IDLE && rx_fall) begin
        rx_ovs_q  <= '0;
        rx_bit_q  <= '0;
        rx_cfg_q  <= cfg_q[3:1];
        rx_perr_q <= 1'b0;
      end else if (tick) begin
        rx_ovs_q <= (rx_ovs_q == CW'(OVS-1)) ? '0 : rx_ovs_q + 1'b1;
        if (rx_mid && rx_st_q == S_DATA) begin
          rx_bit_q <= rx_bit_q + 1'b1;
          rx_sh_q  <= rx_cfg_q[3] ? {rx_sh_q[DATA_W-2:0], rx_maj} : {rx_maj, rx_sh_q[DATA_W-1:1]};
        end
        if (rx_mid && rx_st_q == S_PAR) rx_perr_q <= rx_maj ^ (^rx_sh_q) ^ rx_cfg_q[1];
      end
    end
  end

  assign rx_pop = !n_rd_i && !rxf_empty;

  uart_core_param_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_rxf (
    .clk(clk), .rst(rst), .we_i(rx_push && (!rxf_full || rx_pop)), .wdata_i(rx_sh_q),
    .re_i(rx_pop), .rdata_o(data_o), .full_o(rxf_full), .empty_o(rxf_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      perr_q <= '0; ferr_q <= '0; ovr_q <= '0;
    end else begin
      if (rx_push && rx_perr_q && perr_q != 8'hFF) perr_q <= perr_q + 1'b1;
      if (rx_ferr && ferr_q != 8'hFF) ferr_q <= ferr_q + 1'b1;
      if (rx_push && rxf_full && !rx_pop && ovr_q != 8'hFF) ovr_q <= ovr_q + 1'b1;
    end
  end

  assign p_empty_o      = rxf_empty;
  assign ParityErrNum_o = perr_q;
  assign FrameErrNum_o  = ferr_q;
  assign OverrunNum_o   = ovr_q;
endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: TX waveform, RX parity/frame/overrun, fractional baud, reset.
module tb_uart_core_param;
  logic        clk, rst, p_We_i, n_we_i, n_rd_i, lb_i, Rx_w, rx_drv, lb_mode;
  logic [11:0] div_i;
  logic [3:0]  frac_i, cfg_i;
  logic [7:0]  data_i, data_o, ParityErrNum_o, FrameErrNum_o, OverrunNum_o;
  logic        p_full_o, p_empty_o, p_tx_busy_o, Tx_o;
  int checks, errors, cyc_cnt;

  assign Rx_w = lb_mode ? Tx_o : rx_drv;

  uart_core_param dut (
    .clk(clk), .rst(rst), .p_We_i(p_We_i), .div_i(div_i), .frac_i(frac_i), .cfg_i(cfg_i),
    .data_i(data_i), .n_we_i(n_we_i), .p_full_o(p_full_o), .data_o(data_o), .n_rd_i(n_rd_i),
    .p_empty_o(p_empty_o), .p_tx_busy_o(p_tx_busy_o), .ParityErrNum_o(ParityErrNum_o),
    .FrameErrNum_o(FrameErrNum_o), .OverrunNum_o(OverrunNum_o),
`ifdef UART_LOOPBACK_EN
    .lb_i(lb_i),
`endif
    .Rx_i(Rx_w), .Tx_o(Tx_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_wr(input logic [11:0] d, input logic [3:0] f, input logic [3:0] c);
    @(negedge clk);
    div_i = d; frac_i = f; cfg_i = c; p_We_i = 1'b1;
    @(negedge clk);
    p_We_i = 1'b0;
  endtask

  task automatic wr_tx(input logic [7:0] d);
    @(negedge clk);
    data_i = d; n_we_i = 1'b0;
    @(negedge clk);
    n_we_i = 1'b1;
  endtask

  task automatic pop_rx();
    n_rd_i = 1'b0;
    @(negedge clk);
    n_rd_i = 1'b1;
  endtask

  task automatic wait_tx_low(input int maxc);
    int n;
    n = 0;
    while (Tx_o !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (p_tx_busy_o !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("tx_idle", p_tx_busy_o, 1'b0);
  endtask

  // exp[i] is the line level expected in bit slot i of the frame.
  task automatic tx_check(input string tag, input logic [15:0] exp, input int n, input int bclk, input int lat);
    wait_tx_low(lat);
    chk({tag, "_start_lat"}, Tx_o, 1'b0);
    cyc(bclk / 2);
    for (int i = 0; i < n; i++) begin
      if (i > 0) cyc(bclk);
      chk($sformatf("%s_bit%0d", tag, i), Tx_o, exp[i]);
    end
  endtask

  task automatic rx_bits(input logic [15:0] bits, input int n, input int bclk);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      cyc(bclk);
    end
  endtask

  initial begin
    int t0, d, n;
    logic last;
    checks = 0; errors = 0; cyc_cnt = 0;
    rst = 1'b0; p_We_i = 1'b0; div_i = '0; frac_i = '0; cfg_i = '0; data_i = '0;
    n_we_i = 1'b1; n_rd_i = 1'b1; rx_drv = 1'b1; lb_mode = 1'b0; lb_i = 1'b0;
    cyc(3);
    chk("rst_tx", Tx_o, 1'b1);
    chk("rst_full", p_full_o, 1'b0);
    chk("rst_empty", p_empty_o, 1'b1);
    chk("rst_busy", p_tx_busy_o, 1'b0);
    chk("rst_data", data_o, 8'h00);
    chk("rst_cnt", {ParityErrNum_o, FrameErrNum_o, OverrunNum_o}, 24'h0);
    rst = 1'b1;
    cyc(2);

    // A5, 8N1, 64 clocks per bit
    cfg_wr(12'd4, 4'd0, 4'b0000);
    wr_tx(8'hA5);
    chk("busy_lat", p_tx_busy_o, 1'b1);
    tx_check("a5", 16'b1_10100101_0, 10, 64, 6);
    wait_idle(100);

    // 03 with odd parity: parity bit 1
    cfg_wr(12'd2, 4'd0, 4'b0110);
    wr_tx(8'h03);
    tx_check("par", 16'b1_1_00000011_0, 11, 32, 4);
    wait_idle(100);

    // RX same frame with wrong parity 0: word kept, parity error counted
    rx_bits(16'b1_0_00000011_0, 11, 32);
    cyc(4);
    chk("perr_empty", p_empty_o, 1'b0);
    chk("perr_data", data_o, 8'h03);
    chk("perr_cnt", ParityErrNum_o, 8'd1);
    pop_rx();
    chk("pop_empty", p_empty_o, 1'b1);
    chk("pop_data0", data_o, 8'h00);

    // Correct odd parity: no further error
    rx_bits(16'b1_1_00000011_0, 11, 32);
    cyc(4);
    chk("pok_data", data_o, 8'h03);
    chk("pok_cnt", ParityErrNum_o, 8'd1);
    pop_rx();

    // Stop bit 0: discarded, frame error
    cfg_wr(12'd2, 4'd0, 4'b0000);
    rx_bits(16'b0_01011010_0, 10, 32);
    rx_drv = 1'b1;
    cyc(64);
    chk("ferr_empty", p_empty_o, 1'b1);
    chk("ferr_cnt", FrameErrNum_o, 8'd1);

    // 8-clock glitch: false start
    rx_drv = 1'b0;
    cyc(8);
    rx_drv = 1'b1;
    cyc(400);
    chk("glitch_empty", p_empty_o, 1'b1);
    chk("glitch_ferr", FrameErrNum_o, 8'd1);
    chk("glitch_perr", ParityErrNum_o, 8'd1);

    // MSB first, two stop bits, looped into RX by the bench
    cfg_wr(12'd2, 4'd0, 4'b1001);
    lb_mode = 1'b1;
    wr_tx(8'hC1);
    tx_check("msb", 16'b11_10000011_0, 11, 32, 4);
    chk("stop2_busy", p_tx_busy_o, 1'b1);
    cyc(40);
    chk("stop2_done", p_tx_busy_o, 1'b0);
    chk("msb_rx_data", data_o, 8'hC1);
    pop_rx();
    lb_mode = 1'b0;

    // Fractional divider 21+11/16: every bit boundary at k*347 clocks
    cfg_wr(12'd21, 4'd11, 4'b0000);
    @(negedge clk);
    data_i = 8'h55; n_we_i = 1'b0;
    cyc(3);
    n_we_i = 1'b1;
    wait_tx_low(30);
    chk("frac_start", Tx_o, 1'b0);
    t0 = cyc_cnt;
    last = 1'b0;
    for (int k = 1; k < 30; k++) begin
      n = 0;
      while (Tx_o === last && n < 400) begin
        @(negedge clk);
        n++;
      end
      last = Tx_o;
      d = cyc_cnt - t0 - k * 347;
      chk($sformatf("frac_edge%0d_off%0d", k, d), (d >= -1 && d <= 1), 1'b1);
    end
    wait_idle(1000);

    // 18 writes: 17 accepted; loopback gives 17 RX words into 16-deep FIFO
    cfg_wr(12'd2, 4'd0, 4'b0000);
    lb_mode = 1'b1;
    for (int i = 0; i < 18; i++) begin
      data_i = 8'h10 + 8'(i); n_we_i = 1'b0;
      @(negedge clk);
    end
    n_we_i = 1'b1;
    chk("tx_full", p_full_o, 1'b1);
    wait_idle(8000);
    cyc(40);
    chk("ovr_empty", p_empty_o, 1'b0);
    chk("ovr_cnt", OverrunNum_o, 8'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovr_word%0d", i), data_o, 8'h10 + 8'(i));
      pop_rx();
    end
    chk("ovr_drained", p_empty_o, 1'b1);
    lb_mode = 1'b0;

`ifdef UART_LOOPBACK_EN
    lb_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_i = 8'hE0 + 8'(i); n_we_i = 1'b0;
      @(negedge clk);
    end
    n_we_i = 1'b1;
    n = 0;
    d = 0;
    while (p_tx_busy_o !== 1'b0 && n < 8000) begin
      if (Tx_o !== 1'b1) d++;
      @(negedge clk);
      n++;
    end
    chk("lb_idle", p_tx_busy_o, 1'b0);
    chk("lb_tx_high", d, 0);
    cyc(40);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("lb_word%0d", i), data_o, 8'hE0 + 8'(i));
      pop_rx();
    end
    lb_i = 1'b0;
`endif

    // Reset in the middle of a frame
    wr_tx(8'h00);
    wait_tx_low(10);
    cyc(50);
    chk("mid_low", Tx_o, 1'b0);
    rst = 1'b0;
    cyc(1);
    chk("mid_rst_tx", Tx_o, 1'b1);
    chk("mid_rst_busy", p_tx_busy_o, 1'b0);
    chk("mid_rst_cnt", {ParityErrNum_o, FrameErrNum_o, OverrunNum_o}, 24'h0);
    chk("mid_rst_empty", p_empty_o, 1'b1);
    rst = 1'b1;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
